// File: rtl/hit_stop_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hit_stop_ctrl
// Description : Collision detector and hit-stop sequencer for the goose game.
//               Latches goose/bean overlap during a frame, commits at most one
//               hit per frame boundary, freezes obstacles for a fixed number
//               of frames, then respawns them or holds game-over until a
//               restart button edge.
// Revision    : 1.0 - initial release
// ============================================================================
module hit_stop_ctrl #(
    parameter int HSTOP_FRAMES = 30,
    parameter int LIVES        = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_tick,
    input  logic       frame_tick,
    input  logic       video_on,
    input  logic       goose,
    input  logic       bean,
    input  logic       restart_btn,
    output logic       check_hit,
    output logic       obj_reset,
    output logic       game_over,
    output logic [1:0] lives,
    output logic       flash
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HSTOP   = 2'd1,
        ST_RESPAWN = 2'd2,
        ST_OVER    = 2'd3
    } state_t;

    // Counter runs HSTOP_FRAMES-1 down to 0, expiring on the tick seen at 0.
    localparam logic [7:0] c_cnt_load = 8'(HSTOP_FRAMES - 1);
    localparam logic [1:0] c_lives    = 2'(LIVES);

    state_t     state_q, state_d;
    logic [1:0] lives_q, lives_d;
    logic [7:0] cnt_q, cnt_d;
    logic       latch_q, latch_d;
    logic       restart_prev_q;
    logic       check_hit_q, check_hit_d;
    logic       obj_reset_q, obj_reset_d;
    logic       game_over_q, game_over_d;
    logic       flash_q, flash_d;

    logic       w_ovl;
    logic       w_restart_rise;

    assign w_ovl          = pix_tick & video_on & goose & bean;
    assign w_restart_rise = restart_btn & ~restart_prev_q;

    // Next-state, counter, lives and output decode from the upcoming state.
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        latch_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (frame_tick) begin
                    // Current-cycle overlap counts, so a hit on the boundary pixel is not lost.
                    if (latch_q | w_ovl) begin
                        lives_d = lives_q - 2'd1;
                        cnt_d   = c_cnt_load;
                        state_d = ST_HSTOP;
                    end
                end else begin
                    latch_d = latch_q | w_ovl;
                end
            end
            ST_HSTOP: begin
                if (frame_tick) begin
                    if (cnt_q == 8'd0) begin
                        state_d = (lives_q == 2'd0) ? ST_OVER : ST_RESPAWN;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            ST_RESPAWN: begin
                state_d = ST_RUN;
            end
            ST_OVER: begin
                if (w_restart_rise) begin
                    lives_d = c_lives;
                    state_d = ST_RESPAWN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        check_hit_d = (state_d != ST_RUN);
        obj_reset_d = (state_d == ST_RESPAWN);
        game_over_d = (state_d == ST_OVER);
        flash_d     = (state_d == ST_HSTOP) & cnt_d[2];
    end

    // State and registered outputs; active-low synchronous reset wins over everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_RUN;
            lives_q        <= c_lives;
            cnt_q          <= 8'd0;
            latch_q        <= 1'b0;
            restart_prev_q <= 1'b0;
            check_hit_q    <= 1'b0;
            obj_reset_q    <= 1'b0;
            game_over_q    <= 1'b0;
            flash_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            lives_q        <= lives_d;
            cnt_q          <= cnt_d;
            latch_q        <= latch_d;
            restart_prev_q <= restart_btn;
            check_hit_q    <= check_hit_d;
            obj_reset_q    <= obj_reset_d;
            game_over_q    <= game_over_d;
            flash_q        <= flash_d;
        end
    end

    assign check_hit = check_hit_q;
    assign obj_reset = obj_reset_q;
    assign game_over = game_over_q;
    assign lives     = lives_q;
    assign flash     = flash_q;

endmodule
`default_nettype wire

// File: tb/tb_hit_stop_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hit_stop_ctrl
// Description : Self-checking bench for hit_stop_ctrl. Two instances with
//               different freeze lengths share stimulus; a frame-level model
//               predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hit_stop_ctrl;

    localparam int LIVES = 3;
    localparam int H0    = 4;
    localparam int H1    = 9;

    localparam int M_RUN    = 0;
    localparam int M_FREEZE = 1;
    localparam int M_RESPWN = 2;
    localparam int M_OVER   = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pix_tick = 1'b0, frame_tick = 1'b0, video_on = 1'b0;
    logic       goose = 1'b0, bean = 1'b0, restart_btn = 1'b0;
    logic [1:0] ch, orst, go, fl;
    logic [1:0] lv0, lv1;
    logic       btn_lvl = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // Model: mode, lives, overlap-seen-this-frame, freeze frames still to go.
    int m_mode  [2];
    int m_lives [2];
    int m_left  [2];
    bit m_seen  [2];
    bit m_prev;
    int hf      [2];

    always #5 clk = ~clk;

    hit_stop_ctrl #(.HSTOP_FRAMES(H0), .LIVES(LIVES)) u_dut0 (
        .clk(clk), .reset(reset), .pix_tick(pix_tick), .frame_tick(frame_tick),
        .video_on(video_on), .goose(goose), .bean(bean), .restart_btn(restart_btn),
        .check_hit(ch[0]), .obj_reset(orst[0]), .game_over(go[0]), .lives(lv0), .flash(fl[0])
    );

    hit_stop_ctrl #(.HSTOP_FRAMES(H1), .LIVES(LIVES)) u_dut1 (
        .clk(clk), .reset(reset), .pix_tick(pix_tick), .frame_tick(frame_tick),
        .video_on(video_on), .goose(goose), .bean(bean), .restart_btn(restart_btn),
        .check_hit(ch[1]), .obj_reset(orst[1]), .game_over(go[1]), .lives(lv1), .flash(fl[1])
    );

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit ovl;
        bit rise;
        ovl  = pix_tick & video_on & goose & bean;
        rise = restart_btn & ~m_prev;
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                m_mode[k]  = M_RUN;
                m_lives[k] = LIVES;
                m_seen[k]  = 1'b0;
                m_left[k]  = 0;
            end else begin
                case (m_mode[k])
                    M_RUN: begin
                        if (frame_tick) begin
                            if (m_seen[k] || ovl) begin
                                m_lives[k] = m_lives[k] - 1;
                                m_left[k]  = hf[k];
                                m_mode[k]  = M_FREEZE;
                            end
                            m_seen[k] = 1'b0;
                        end else if (ovl) begin
                            m_seen[k] = 1'b1;
                        end
                    end
                    M_FREEZE: begin
                        m_seen[k] = 1'b0;
                        if (frame_tick) begin
                            m_left[k] = m_left[k] - 1;
                            if (m_left[k] == 0)
                                m_mode[k] = (m_lives[k] == 0) ? M_OVER : M_RESPWN;
                        end
                    end
                    M_RESPWN: begin
                        m_seen[k] = 1'b0;
                        m_mode[k] = M_RUN;
                    end
                    default: begin
                        m_seen[k] = 1'b0;
                        if (rise) begin
                            m_lives[k] = LIVES;
                            m_mode[k]  = M_RESPWN;
                        end
                    end
                endcase
            end
        end
        m_prev = reset ? restart_btn : 1'b0;
    endtask

    // One clock: drive on the falling edge, predict, then compare after the rising edge.
    task automatic cyc(input logic rst_n, input logic pt, input logic ft,
                       input logic vo, input logic g, input logic b);
        @(negedge clk);
        reset       = rst_n;
        pix_tick    = pt;
        frame_tick  = ft;
        video_on    = vo;
        goose       = g;
        bean        = b;
        restart_btn = btn_lvl;
        model_step();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("check_hit[%0d]", k), 8'(ch[k]), 8'(m_mode[k] != M_RUN));
            check_val($sformatf("obj_reset[%0d]", k), 8'(orst[k]), 8'(m_mode[k] == M_RESPWN));
            check_val($sformatf("game_over[%0d]", k), 8'(go[k]), 8'(m_mode[k] == M_OVER));
            check_val($sformatf("lives[%0d]", k), 8'((k == 0) ? lv0 : lv1), 8'(m_lives[k]));
            check_val($sformatf("flash[%0d]", k), 8'(fl[k]),
                      8'((m_mode[k] == M_FREEZE) && ((((m_left[k] - 1) >> 2) & 1) == 1)));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic hit_now();
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        hf[0]  = H0;
        hf[1]  = H1;
        m_prev = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = M_RUN; m_lives[k] = LIVES; m_left[k] = 0; m_seen[k] = 1'b0;
        end

        // Reset state
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("reset_lives", 8'(lv0), 8'd3);
        check_val("reset_check_hit", 8'(ch[0]), 8'd0);
        check_val("reset_game_over", 8'(go[0]), 8'd0);

        // Single overlap pixel, committed at the next frame boundary
        idle(2);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(3);
        check_val("pre_commit_check_hit", 8'(ch[0]), 8'd0);
        tick();
        check_val("hit_check_hit", 8'(ch[0]), 8'd1);
        check_val("hit_lives", 8'(lv0), 8'd2);
        repeat (3) begin idle(2); tick(); end
        check_val("freeze_no_early_respawn", 8'(orst[0]), 8'd0);
        idle(2);
        tick();
        check_val("respawn_pulse", 8'(orst[0]), 8'd1);
        idle(1);
        check_val("respawn_single", 8'(orst[0]), 8'd0);
        check_val("run_after_respawn", 8'(ch[0]), 8'd0);

        // Many overlap pixels in one frame give one decrement
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (500) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        check_val("many_pixels_lives", 8'(lv0), 8'd2);
        repeat (4) begin idle(1); tick(); end
        idle(1);

        // Overlap without a valid visible pixel is ignored
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        check_val("invalid_no_hit", 8'(ch[0]), 8'd0);
        check_val("invalid_lives", 8'(lv0), 8'd2);

        // Overlap on the frame_tick cycle commits; overlap during freeze does not
        hit_now();
        check_val("same_cycle_hit", 8'(ch[0]), 8'd1);
        check_val("same_cycle_lives", 8'(lv0), 8'd1);
        repeat (4) begin repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1); tick(); end
        check_val("freeze_overlap_lives", 8'(lv0), 8'd1);
        idle(1);

        // Last life lost with restart held high: game over, no restart
        btn_lvl = 1'b1;
        hit_now();
        check_val("last_hit_lives", 8'(lv0), 8'd0);
        repeat (4) begin idle(1); tick(); end
        idle(3);
        check_val("over_game_over", 8'(go[0]), 8'd1);
        check_val("over_check_hit", 8'(ch[0]), 8'd1);

        // Reset with the button still high lands in RUN without restart action
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        check_val("held_btn_reset_run", 8'(ch[0]), 8'd0);
        check_val("held_btn_reset_obj", 8'(orst[0]), 8'd0);

        // Back to game over while the button stays high, then drop and raise it
        repeat (3) begin
            hit_now();
            repeat (4) begin idle(1); tick(); end
            idle(1);
        end
        idle(2);
        check_val("held_btn_over", 8'(go[0]), 8'd1);
        btn_lvl = 1'b0;
        idle(2);
        btn_lvl = 1'b1;
        idle(1);
        check_val("restart_obj_reset", 8'(orst[0]), 8'd1);
        check_val("restart_lives", 8'(lv0), 8'd3);
        check_val("restart_game_over", 8'(go[0]), 8'd0);
        idle(1);
        check_val("restart_run", 8'(ch[0]), 8'd0);
        btn_lvl = 1'b0;

        // Reset while frozen with the counter at 2
        hit_now();
        tick();
        idle(1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        check_val("midfreeze_check_hit", 8'(ch[0]), 8'd0);
        check_val("midfreeze_lives", 8'(lv0), 8'd3);
        check_val("midfreeze_obj_reset", 8'(orst[0]), 8'd0);
        check_val("midfreeze_flash", 8'(fl[0]), 8'd0);

        // Randomized traffic checked against the model every cycle
        for (int i = 0; i < 3000; i++) begin
            if (($urandom % 30) == 0) btn_lvl = ~btn_lvl;
            cyc(($urandom % 400) != 0, 1'($urandom % 2), ($urandom % 25) == 0,
                ($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hit_stop_ctrl.md
# hit_stop_ctrl

Collision and hit-stop controller sitting directly downstream of `draw_bean`. Each pixel it ANDs the goose sprite flag with the `bean` flag. A detected overlap is committed at the next frame boundary. On commit the block freezes the scrolling obstacles through `check_hit` for a fixed number of frames, decrements lives, and then either respawns the obstacles by pulsing their `reset` or enters game-over until the player restarts.

## Interface
Parameters:
- `HSTOP_FRAMES`, 30, frames the freeze lasts after a committed hit (1–255)
- `LIVES`, 3, lives loaded at reset and restart (1–3)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-low; sampled on `clk` rising edge
- `pix_tick`  in  1  one-cycle pixel enable
- `frame_tick`  in  1  one-cycle pulse at start of vertical blank
- `video_on`  in  1  pixel is in the visible area
- `goose`  in  1  goose sprite covers current pixel
- `bean`  in  1  obstacle covers current pixel (from `draw_bean`)
- `restart_btn`  in  1  debounced restart level
- `check_hit`  out  1  freeze request to `draw_bean`
- `obj_reset`  out  1  one-cycle active-high obstacle reset to `draw_bean`
- `game_over`  out  1  game-over indicator
- `lives`  out  2  remaining lives
- `flash`  out  1  goose blink enable during freeze

## Operation
- States: RUN, HSTOP, RESPAWN, OVER. Reset enters RUN.
- Reset values:
  - `check_hit`=0, `obj_reset`=0, `game_over`=0, `flash`=0
  - `lives`=LIVES
  - overlap latch = 0, frame counter = 0, restart edge register = 0
- Overlap latch:
  - Set when `pix_tick & video_on & goose & bean` and state is RUN.
  - Cleared in every state other than RUN, and on each `frame_tick` in RUN.
- RUN, on `frame_tick`:
  - If (latch | current-cycle overlap term) is set: `lives`←`lives`−1, frame counter←HSTOP_FRAMES−1, go to HSTOP.
  - At most one hit is committed per frame, regardless of overlap pixel count.
- HSTOP:
  - `check_hit`=1.
  - On each `frame_tick`, decrement the counter.
  - On `frame_tick` with counter==0: go to OVER if `lives`==0, else RESPAWN.
  - `flash` = counter bit 2.
- RESPAWN:
  - Lasts exactly one cycle with `obj_reset`=1 and `check_hit`=1, then RUN.
- OVER:
  - `check_hit`=1, `game_over`=1.
  - On a rising edge of `restart_btn` (registered previous value): `lives`←LIVES, go to RESPAWN.
- `restart_btn` is ignored in RUN, HSTOP and RESPAWN. The edge register is still updated every cycle.
- `lives` never wraps: a decrement from 0 is impossible by construction, because OVER is entered at 0.
- Counter is 8 bits. HSTOP_FRAMES=1 gives a one-frame freeze.

## Timing
- All outputs are registered and are decoded from the state visible one cycle after the deciding edge.
- `frame_tick` at edge N that commits a hit:
  - `check_hit`=1 and the decremented `lives` appear after edge N.
- HSTOP expiry on `frame_tick` at edge M:
  - `obj_reset`=1 for the cycle after edge M only.
  - RUN, with `check_hit`=0, takes effect after edge M+1.
- Freeze length is HSTOP_FRAMES `frame_tick` pulses, counted from the first `frame_tick` after entry.
- Simultaneous overlap pixel and `frame_tick` in RUN: the hit commits in that cycle.
- `reset` low mid-freeze or in OVER: all state returns to reset values on the next edge. `obj_reset` is not pulsed.
- `reset` dominates all other inputs.

## Test plan
- Collision in RUN:
  - Stimulus: LIVES=3, HSTOP_FRAMES=4; drive one overlap pixel in frame 0, then `frame_tick`.
  - Required: `check_hit`=1 and `lives`=2 next cycle.
  - Required: after 4 further `frame_tick`s, a single-cycle `obj_reset`; `check_hit`=0 one cycle later.
- Many overlap pixels in one frame:
  - Stimulus: 500 overlap pixels in the same frame.
  - Required: exactly one decrement (`lives` 3→2).
- Overlap outside valid pixels:
  - Stimulus: overlap with `video_on`=0, or with `pix_tick`=0.
  - Required: no hit; state stays RUN.
- Game over and restart:
  - Stimulus: three committed hits.
  - Required: `lives`=0, then after the freeze `game_over`=1 and `check_hit`=1 held.
  - Stimulus: hold `restart_btn` high across reset release.
  - Required: no restart.
  - Stimulus: drop `restart_btn`, then raise it.
  - Required: `obj_reset` pulse, `lives`=3, `game_over`=0, RUN.
- Edge cases:
  - Overlap asserted in the same cycle as `frame_tick`: required hit commit.
  - Overlap during HSTOP: required no additional decrement.
- Reset mid-freeze:
  - Stimulus: `reset`=0 for one cycle during HSTOP at counter=2.
  - Required: next cycle `check_hit`=0, `lives`=3, `obj_reset`=0, `flash`=0.
